// File: rtl/mem_stage_reg_pkg.sv
// Shared widths, bus layouts and load-type bit positions for the memory-access stage.
package mem_stage_reg_pkg;

  localparam int ES2MS_LEN  = 85;
  localparam int MS2WS_LEN  = 111;
  localparam int RF_ZIP_LEN = 40;
  localparam int EXC_W      = 8;

  // Bit positions inside ld_zip = {ld_b, ld_bu, ld_h, ld_hu, ld_w}
  localparam int LD_B  = 4;
  localparam int LD_BU = 3;
  localparam int LD_H  = 2;
  localparam int LD_HU = 1;
  localparam int LD_W  = 0;

  typedef struct packed {
    logic             mem_req;
    logic [4:0]       ld_zip;
    logic             rf_we;
    logic [4:0]       rf_waddr;
    logic             csr_re;
    logic [31:0]      alu_result;
    logic [31:0]      pc;
    logic [EXC_W-1:0] except;
  } es2ms_t;

  typedef struct packed {
    logic [31:0]      pc;
    logic             rf_we;
    logic [4:0]       rf_waddr;
    logic             csr_re;
    logic [31:0]      final_wdata;
    logic [EXC_W-1:0] except;
    logic [31:0]      vaddr;
  } ms2ws_t;

  typedef struct packed {
    logic        csr_re;
    logic        mem_pending;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] wdata;
  } rf_zip_t;

  function automatic logic is_load(input logic [4:0] ld_zip);
    return |ld_zip;
  endfunction

endpackage

// File: rtl/mem_stage_reg_load_align.sv
// Byte/half/word extraction with sign or zero extension for load results.
module mem_load_align
  import mem_stage_reg_pkg::*;
(
  input  logic [4:0]  ld_zip,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] wdata
);

  logic [7:0]  byte_lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_lane[gi] = rdata[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    byte_sel = byte_lane[addr];
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    wdata    = '0;
    if (ld_zip[LD_B])       wdata = {{24{byte_sel[7]}}, byte_sel};
    else if (ld_zip[LD_BU]) wdata = {24'b0, byte_sel};
    else if (ld_zip[LD_H])  wdata = {{16{half_sel[15]}}, half_sel};
    else if (ld_zip[LD_HU]) wdata = {16'b0, half_sel};
    else if (ld_zip[LD_W])  wdata = rdata;
  end

endmodule

// File: rtl/mem_stage_reg.sv
// Memory-access pipeline stage: waits for data_ok, extracts load data, drops flushed responses.
// Optional macro MS_FWD_LOAD_DATA_EN forwards arrived load data to decode via ms_rf_zip.
module mem_stage_reg
  import mem_stage_reg_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  es2ms_valid,
  input  logic [ES2MS_LEN-1:0]  es2ms_bus,
  output logic                  ms_allowin,
  input  logic                  ws_allowin,
  output logic                  ms2ws_valid,
  output logic [MS2WS_LEN-1:0]  ms2ws_bus,
  output logic [RF_ZIP_LEN-1:0] ms_rf_zip,
  output logic                  ms_ex,
  input  logic                  wb_ex,
  input  logic                  data_sram_data_ok,
  input  logic [31:0]           data_sram_rdata
);

  es2ms_t      bus_q, bus_d;
  logic        ms_valid_q, ms_valid_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] rdata_buf_q, rdata_buf_d;
  logic [1:0]  discard_cnt_q, discard_cnt_d;

  logic        data_hit, data_arrived, ms_ready_go, leaving;
  logic        cnt_inc, cnt_dec;
  logic [31:0] load_rdata, load_data, final_wdata;
  ms2ws_t      ws_out;
  rf_zip_t     rf_out;

  assign data_hit     = data_sram_data_ok & (discard_cnt_q == 2'd0);
  assign data_arrived = buf_valid_q | data_hit;
  assign ms_ready_go  = ~bus_q.mem_req | data_arrived;
  assign ms_allowin   = ~ms_valid_q | (ms_ready_go & ws_allowin);
  assign ms2ws_valid  = ms_valid_q & ms_ready_go;
  assign leaving      = ms2ws_valid & ws_allowin;
  assign ms_ex        = ms_valid_q & (|bus_q.except);
  assign load_rdata   = buf_valid_q ? rdata_buf_q : data_sram_rdata;

  // A flushed request whose response has not come back leaves one response to drop.
  assign cnt_inc = wb_ex & ms_valid_q & bus_q.mem_req & ~data_arrived;
  assign cnt_dec = data_sram_data_ok & (discard_cnt_q != 2'd0);

  mem_load_align u_align (
    .ld_zip (bus_q.ld_zip),
    .addr   (bus_q.alu_result[1:0]),
    .rdata  (load_rdata),
    .wdata  (load_data)
  );

  assign final_wdata = is_load(bus_q.ld_zip) ? load_data : bus_q.alu_result;

  always_comb begin
    ms_valid_d    = ms_valid_q;
    bus_d         = bus_q;
    buf_valid_d   = buf_valid_q;
    rdata_buf_d   = rdata_buf_q;
    discard_cnt_d = discard_cnt_q;

    if (wb_ex) begin
      ms_valid_d = 1'b0;
    end else if (ms_allowin) begin
      ms_valid_d = es2ms_valid;
      if (es2ms_valid) bus_d = es2ms_t'(es2ms_bus);
    end

    if (wb_ex || leaving) begin
      buf_valid_d = 1'b0;
    end else if (data_hit && ms_valid_q && bus_q.mem_req && !buf_valid_q) begin
      buf_valid_d = 1'b1;
      rdata_buf_d = data_sram_rdata;
    end

    if (cnt_inc && !cnt_dec && discard_cnt_q != 2'd3) discard_cnt_d = discard_cnt_q + 2'd1;
    else if (cnt_dec && !cnt_inc)                     discard_cnt_d = discard_cnt_q - 2'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid_q    <= 1'b0;
      bus_q         <= '0;
      buf_valid_q   <= 1'b0;
      rdata_buf_q   <= '0;
      discard_cnt_q <= 2'd0;
    end else begin
      ms_valid_q    <= ms_valid_d;
      bus_q         <= bus_d;
      buf_valid_q   <= buf_valid_d;
      rdata_buf_q   <= rdata_buf_d;
      discard_cnt_q <= discard_cnt_d;
    end
  end

  always_comb begin
    ws_out.pc          = bus_q.pc;
    ws_out.rf_we       = bus_q.rf_we;
    ws_out.rf_waddr    = bus_q.rf_waddr;
    ws_out.csr_re      = bus_q.csr_re;
    ws_out.final_wdata = final_wdata;
    ws_out.except      = bus_q.except;
    ws_out.vaddr       = bus_q.alu_result;

    rf_out.csr_re   = ms_valid_q & bus_q.csr_re;
    rf_out.rf_we    = ms_valid_q & bus_q.rf_we;
    rf_out.rf_waddr = bus_q.rf_waddr;
`ifdef MS_FWD_LOAD_DATA_EN
    rf_out.mem_pending = ms_valid_q & is_load(bus_q.ld_zip) & ~data_arrived;
    rf_out.wdata       = (is_load(bus_q.ld_zip) & data_arrived) ? load_data : bus_q.alu_result;
`else
    rf_out.mem_pending = ms_valid_q & is_load(bus_q.ld_zip);
    rf_out.wdata       = bus_q.alu_result;
`endif
  end

  assign ms2ws_bus = ws_out;
  assign ms_rf_zip = rf_out;

endmodule

// File: tb/tb_mem_stage_reg.sv
// Directed scoreboard bench for mem_stage_reg: loads, buffering, flush/discard, exceptions, reset.
module tb_mem_stage_reg;

  logic         clk = 1'b0;
  logic         resetn;
  logic         es2ms_valid;
  logic [84:0]  es2ms_bus;
  logic         ms_allowin;
  logic         ws_allowin;
  logic         ms2ws_valid;
  logic [110:0] ms2ws_bus;
  logic [39:0]  ms_rf_zip;
  logic         ms_ex;
  logic         wb_ex;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [110:0] exp_q[$];
  logic [31:0]  pc_ctr = 32'h1c00_0000;

  always #5 clk = ~clk;

  mem_stage_reg dut (
    .clk               (clk),
    .resetn            (resetn),
    .es2ms_valid       (es2ms_valid),
    .es2ms_bus         (es2ms_bus),
    .ms_allowin        (ms_allowin),
    .ws_allowin        (ws_allowin),
    .ms2ws_valid       (ms2ws_valid),
    .ms2ws_bus         (ms2ws_bus),
    .ms_rf_zip         (ms_rf_zip),
    .ms_ex             (ms_ex),
    .wb_ex             (wb_ex),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata)
  );

  function automatic logic [84:0] mk_bus(input logic mreq, input logic [4:0] zip, input logic we,
      input logic [4:0] wa, input logic cre, input logic [31:0] alu, input logic [31:0] pc,
      input logic [7:0] exc);
    return {mreq, zip, we, wa, cre, alu, pc, exc};
  endfunction

  function automatic logic [110:0] mk_out(input logic [31:0] pc, input logic we, input logic [4:0] wa,
      input logic cre, input logic [31:0] fw, input logic [7:0] exc, input logic [31:0] va);
    return {pc, we, wa, cre, fw, exc, va};
  endfunction

  function automatic logic [31:0] ext(input logic [4:0] zip, input logic [1:0] a, input logic [31:0] d);
    logic [31:0] sb, sh;
    sb = d >> (8 * a);
    sh = d >> (16 * a[1]);
    case (zip)
      5'b10000: return {{24{sb[7]}}, sb[7:0]};
      5'b01000: return {24'h0, sb[7:0]};
      5'b00100: return {{16{sh[15]}}, sh[15:0]};
      5'b00010: return {16'h0, sh[15:0]};
      5'b00001: return d;
      default:  return 32'h0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample at the falling edge; hand-off compared against the scoreboard head.
  task automatic sample(input logic exp_v);
    @(negedge clk);
    chk("ms2ws_valid", {127'b0, ms2ws_valid}, {127'b0, exp_v});
    if (ms2ws_valid && !wb_ex) begin
      chk("scoreboard_nonempty", {127'b0, exp_q.size() != 0}, 128'd1);
      if (exp_q.size() != 0) begin
        chk("ms2ws_bus", {17'b0, ms2ws_bus}, {17'b0, exp_q[0]});
        if (ws_allowin) void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic exp_v);
    sample(exp_v);
    adv();
  endtask

  task automatic idle();
    es2ms_valid       = 1'b0;
    wb_ex             = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = $urandom;
    ws_allowin        = 1'b1;
  endtask

  // Load with response after lat cycles, writeback stalled for hold cycles from data_ok.
  task automatic run_load(input logic [4:0] zip, input logic [31:0] alu, input logic [31:0] rd,
      input int lat, input int hold);
    logic [31:0] fw;
    logic        exp_pend;
    logic [31:0] exp_rfw;
    fw      = ext(zip, alu[1:0], rd);
    pc_ctr  = pc_ctr + 32'd4;
    exp_pend = 1'b1;
    exp_rfw  = alu;
`ifdef MS_FWD_LOAD_DATA_EN
    exp_pend = 1'b0;
    exp_rfw  = fw;
`endif
    exp_q.push_back(mk_out(pc_ctr, 1'b1, 5'd9, 1'b0, fw, 8'h0, alu));
    es2ms_valid = 1'b1;
    es2ms_bus   = mk_bus(1'b1, zip, 1'b1, 5'd9, 1'b0, alu, pc_ctr, 8'h0);
    sample(1'b0);
    chk("allowin_empty", {127'b0, ms_allowin}, 128'd1);
    adv();
    es2ms_valid = 1'b0;
    for (int i = 1; i < lat; i++) begin
      sample(1'b0);
      chk("pending_wait", {127'b0, ms_rf_zip[38]}, 128'd1);
      adv();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = rd;
    ws_allowin        = (hold == 0);
    sample(1'b1);
    chk("pending_arrived", {127'b0, ms_rf_zip[38]}, {127'b0, exp_pend});
    chk("rf_zip_wdata", {96'b0, ms_rf_zip[31:0]}, {96'b0, exp_rfw});
    adv();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = ~rd;
    for (int i = 1; i < hold; i++) begin
      sample(1'b1);
      chk("buf_valid_hold", {127'b0, dut.buf_valid_q}, 128'd1);
      chk("allowin_stalled", {127'b0, ms_allowin}, 128'd0);
      adv();
    end
    if (hold > 0) begin
      ws_allowin = 1'b1;
      cyc(1'b1);
    end
    sample(1'b0);
    chk("queue_drained", {96'b0, exp_q.size()}, 128'd0);
    adv();
  endtask

  initial begin
    resetn = 1'b0;
    es2ms_bus = '0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ms2ws_valid", {127'b0, ms2ws_valid}, 128'd0);
    chk("rst_ms_allowin", {127'b0, ms_allowin}, 128'd1);
    chk("rst_ms_ex", {127'b0, ms_ex}, 128'd0);
    chk("rst_rf_zip", {88'b0, ms_rf_zip}, 128'd0);
    chk("rst_ms2ws_bus", {17'b0, ms2ws_bus}, 128'd0);
    chk("rst_discard", {126'b0, dut.discard_cnt_q}, 128'd0);
    adv();
    resetn = 1'b1;
    adv();

    // Loads of every width, varying latency and writeback stall
    run_load(5'b10000, 32'h0000_1003, 32'h80FF_0000, 1, 0);
    run_load(5'b00010, 32'h0000_2002, 32'hBEEF_1234, 1, 3);
    run_load(5'b00100, 32'h0000_2000, 32'h1234_8001, 3, 0);
    run_load(5'b01000, 32'h0000_2001, 32'h0000_AB00, 2, 2);
    run_load(5'b00001, 32'h0000_2004, 32'h1111_2222, 1, 2);

    // Flush with a load outstanding; its late response must be dropped
    pc_ctr = pc_ctr + 32'd4;
    es2ms_valid = 1'b1;
    es2ms_bus   = mk_bus(1'b1, 5'b00001, 1'b1, 5'd7, 1'b0, 32'h3000, pc_ctr, 8'h0);
    cyc(1'b0);
    es2ms_valid = 1'b0;
    cyc(1'b0);
    wb_ex = 1'b1;
    cyc(1'b0);
    wb_ex = 1'b0;
    pc_ctr = pc_ctr + 32'd4;
    exp_q.push_back(mk_out(pc_ctr, 1'b1, 5'd8, 1'b0, 32'hCAFE_F00D, 8'h0, 32'h3004));
    es2ms_valid = 1'b1;
    es2ms_bus   = mk_bus(1'b1, 5'b00001, 1'b1, 5'd8, 1'b0, 32'h3004, pc_ctr, 8'h0);
    sample(1'b0);
    chk("discard_after_flush", {126'b0, dut.discard_cnt_q}, 128'd1);
    chk("allowin_after_flush", {127'b0, ms_allowin}, 128'd1);
    adv();
    es2ms_valid       = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hDEAD_BEEF;
    sample(1'b0);
    chk("stale_blocks", {127'b0, ms_allowin}, 128'd0);
    adv();
    data_sram_rdata = 32'hCAFE_F00D;
    sample(1'b1);
    chk("discard_drained", {126'b0, dut.discard_cnt_q}, 128'd0);
    adv();
    idle();
    cyc(1'b0);

    // Flush coinciding with the current load's own response: nothing to discard
    pc_ctr = pc_ctr + 32'd4;
    es2ms_valid = 1'b1;
    es2ms_bus   = mk_bus(1'b1, 5'b10000, 1'b1, 5'd4, 1'b0, 32'h4001, pc_ctr, 8'h0);
    cyc(1'b0);
    es2ms_valid       = 1'b0;
    data_sram_data_ok = 1'b1;
    wb_ex             = 1'b1;
    cyc(1'b1);
    idle();
    sample(1'b0);
    chk("same_cycle_discard", {126'b0, dut.discard_cnt_q}, 128'd0);
    chk("same_cycle_buf", {127'b0, dut.buf_valid_q}, 128'd0);
    adv();
    run_load(5'b00001, 32'h0000_4008, 32'h5A5A_A5A5, 1, 0);

    // Excepting ALU op followed back-to-back by a plain ALU op
    pc_ctr = pc_ctr + 32'd4;
    exp_q.push_back(mk_out(pc_ctr, 1'b1, 5'd3, 1'b0, 32'h1234, 8'h04, 32'h1234));
    es2ms_valid = 1'b1;
    es2ms_bus   = mk_bus(1'b0, 5'b0, 1'b1, 5'd3, 1'b0, 32'h1234, pc_ctr, 8'h04);
    sample(1'b0);
    chk("ms_ex_before", {127'b0, ms_ex}, 128'd0);
    adv();
    pc_ctr = pc_ctr + 32'd4;
    exp_q.push_back(mk_out(pc_ctr, 1'b1, 5'd6, 1'b1, 32'h55, 8'h0, 32'h55));
    es2ms_bus = mk_bus(1'b0, 5'b0, 1'b1, 5'd6, 1'b1, 32'h55, pc_ctr, 8'h0);
    sample(1'b1);
    chk("ms_ex_set", {127'b0, ms_ex}, 128'd1);
    chk("allowin_b2b", {127'b0, ms_allowin}, 128'd1);
    chk("rf_zip_exc", {88'b0, ms_rf_zip}, {88'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h1234});
    adv();
    es2ms_valid = 1'b0;
    sample(1'b1);
    chk("ms_ex_clear", {127'b0, ms_ex}, 128'd0);
    chk("rf_zip_csr", {88'b0, ms_rf_zip}, {88'b0, 1'b1, 1'b0, 1'b1, 5'd6, 32'h55});
    adv();
    cyc(1'b0);

    // Asynchronous reset while a load waits for its response
    pc_ctr = pc_ctr + 32'd4;
    es2ms_valid = 1'b1;
    es2ms_bus   = mk_bus(1'b1, 5'b00001, 1'b1, 5'd2, 1'b1, 32'h6000, pc_ctr, 8'h0);
    cyc(1'b0);
    es2ms_valid = 1'b0;
    #2;
    chk("pre_reset_allowin", {127'b0, ms_allowin}, 128'd0);
    resetn = 1'b0;
    #1;
    chk("async_allowin", {127'b0, ms_allowin}, 128'd1);
    chk("async_rf_zip", {88'b0, ms_rf_zip}, 128'd0);
    chk("async_bus", {17'b0, ms2ws_bus}, 128'd0);
    adv();
    resetn = 1'b1;
    cyc(1'b0);
    chk("final_queue_empty", {96'b0, exp_q.size()}, 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/mem_stage_reg.md
# mem_stage_reg

Memory-access pipeline stage placed directly downstream of the execute stage. It latches the execute-stage bus, waits for the data-SRAM `data_ok` response of any load or store issued by execute, and extracts and sign- or zero-extends load data. It forwards the register-file write information to decode, then hands the result to writeback. It also discards responses that belong to requests cancelled by a writeback exception flush.

## Interface
Parameters: none. Widths come from shared macros.
- `clk`  in  1  — the single clock.
- `resetn`  in  1  — reset, asynchronous, active-low.
- `es2ms_valid`  in  1  — execute stage holds a valid instruction.
- `es2ms_bus`  in  `ES2MS_LEN` (85)  — {mem_req[84], ld_zip[83:79] = {ld_b, ld_bu, ld_h, ld_hu, ld_w}, rf_we[78], rf_waddr[77:73], csr_re[72], alu_result[71:40], pc[39:8], except[7:0]}.
- `ms_allowin`  out  1  — stage can accept an instruction this cycle.
- `ws_allowin`  in  1  — writeback can accept an instruction.
- `ms2ws_valid`  out  1  — result is valid toward writeback.
- `ms2ws_bus`  out  `MS2WS_LEN` (111)  — {pc, rf_we, rf_waddr, csr_re, final_wdata, except[7:0], vaddr}.
- `ms_rf_zip`  out  40  — {csr_re, res_from_mem_pending, rf_we, rf_waddr, wdata}. Every flag bit is gated by `ms_valid`.
- `ms_ex`  out  1  — `ms_valid & |except`. Execute uses it to suppress new memory requests.
- `wb_ex`  in  1  — flush from writeback (exception or ertn).
- `data_sram_data_ok`  in  1  — response strobe.
- `data_sram_rdata`  in  32  — response data.

## Operation
- Internal state:
  - `ms_valid`
  - the latched bus fields
  - `rdata_buf[31:0]` and `buf_valid`
  - `discard_cnt[1:0]`
- Accept rule: the bus is latched when `es2ms_valid & ms_allowin`. `ms_valid` is loaded with `es2ms_valid` whenever `ms_allowin` is high. `wb_ex` overrides both and clears `ms_valid`.
- `data_hit = data_sram_data_ok & (discard_cnt == 0)`.
- `data_arrived = buf_valid | data_hit`.
- `ms_ready_go = ~mem_req | data_arrived`.
- `ms_allowin = ~ms_valid | ms_ready_go & ws_allowin`.
- `ms2ws_valid = ms_valid & ms_ready_go`.
- Response buffer:
  - When `data_hit & ms_valid & mem_req & ~buf_valid` and the instruction is not leaving this cycle, capture `rdata_buf` and set `buf_valid`.
  - `buf_valid` clears when the instruction leaves (`ms2ws_valid & ws_allowin`) or on `wb_ex`.
- Discard counter:
  - Increment on `wb_ex` when `ms_valid & mem_req & ~data_arrived`, because that request is still outstanding.
  - Decrement on `data_sram_data_ok` while `discard_cnt != 0`; that response is dropped.
  - If increment and decrement occur in the same cycle, the count is unchanged.
  - The count never exceeds 3 and never goes below 0.
- Load data source: `rdata_buf` when `buf_valid`, otherwise `data_sram_rdata`.
- Load extraction, using `a = alu_result[1:0]`:
  - ld_b / ld_bu: select byte `a`, then sign- or zero-extend to 32 bits.
  - ld_h / ld_hu: select half `a[1]`, then sign- or zero-extend.
  - ld_w: pass the word through.
- `final_wdata` = the extracted load data when `|ld_zip`, otherwise `alu_result`.
- `vaddr` = `alu_result`. It is carried for BADV reporting.
- `res_from_mem_pending = ms_valid & |ld_zip`. This is overridden by `MS_FWD_LOAD_DATA_EN`, described below.
- Instructions with `|except` have `mem_req = 0` (execute guarantees this). They pass through without waiting.

## Timing
- Reset values:
  - Outputs: `ms_valid` = 0, `ms2ws_valid` = 0, `ms_allowin` = 1, `ms_ex` = 0, `ms_rf_zip` = 0, `ms2ws_bus` = 0.
  - Internal state: `buf_valid` = 0, `discard_cnt` = 0.
- Non-memory instruction: one cycle in the stage. It leaves in the cycle after acceptance if `ws_allowin` is high.
- Memory instruction: it leaves in the same cycle that `data_ok` arrives, if `ws_allowin` is high. Otherwise it leaves from the buffer on a later cycle.
- `data_ok` may arrive in the cycle immediately after acceptance at the earliest. No upper bound applies.
- `wb_ex` has priority over accept: the same-cycle `es2ms_valid` is dropped.
- Asynchronous reset in the middle of a request clears everything. Any later stale `data_ok` is not tracked; the SRAM side is reset together with this stage.

## Configuration
- `MS_FWD_LOAD_DATA_EN` defined:
  - Once `data_arrived` is true, `res_from_mem_pending` drops to 0 and `ms_rf_zip.wdata` carries the extended load data, so decode can forward without stalling.
  - Before the data arrives, `res_from_mem_pending` is 1.
- `MS_FWD_LOAD_DATA_EN` not defined:
  - `res_from_mem_pending` stays 1 for as long as a load is in the stage.
  - `ms_rf_zip.wdata` = `alu_result`.

## Structure
- Shared `macro.h` holds:
  - `ES2MS_LEN` = 85 and `MS2WS_LEN` = 111
  - the bus field offsets
  - the `ld_zip` bit positions
  - the exception-vector width (8)
- One combinational sub-module, `mem_load_align`, with inputs (`ld_zip`, `addr[1:0]`, `rdata[31:0]`) and output (`wdata[31:0]`).
- Sequential control stays in `mem_stage_reg`.

## Test plan
- ld_b, `alu_result = 0x1003`, `rdata = 0x80FF_0000`, `data_ok` one cycle after accept with `ws_allowin = 1` → `final_wdata = 0xFFFF_FF80`, `ms2ws_valid` pulses once.
- ld_hu, `addr[1:0] = 2`, `rdata = 0xBEEF_1234`, `ws_allowin = 0` for 3 cycles after `data_ok` → `buf_valid = 1`, `final_wdata = 0x0000_BEEF` is held stable and leaves when `ws_allowin` rises.
- Load outstanding, then `wb_ex` → `ms_valid` = 0, `discard_cnt` = 1. The next `data_ok` with `rdata = 0xDEAD_BEEF` is dropped. A following load's `data_ok` is accepted normally.
- `wb_ex` in the same cycle as `data_ok` for the current load → `discard_cnt` stays 0, and the instruction is flushed rather than written back.
- add with `alu_result = 0x1234`, `except = 0x04` → `ms_ex = 1`, `ms2ws_valid` one cycle after accept, no wait for `data_ok`.
- Under `MS_FWD_LOAD_DATA_EN`: ld_w, `rdata = 0x1111_2222`, `ws_allowin = 0` → `res_from_mem_pending` goes 1→0 on `data_ok`, `ms_rf_zip.wdata = 0x1111_2222`.
